// File: rtl/mc_control.sv
// Multi-cycle RV32 subset control unit: sequences fetch, decode, memory, ALU, branch and jal
// steps, with a memory-wait timeout and a sticky trap state for illegal or stalled operations.
module mc_control #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [2:0] alu_control,
  output logic       trap
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // Count value at which a still-unanswered request gives up.
  localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StFetch,
    StDecode,
    StMemAdr,
    StMemRead,
    StMemWb,
    StMemWrite,
    StExecR,
    StExecI,
    StAluWb,
    StBranch,
    StJal,
    StTrap
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mem_busy;
  logic       timed_out;
  logic [2:0] exec_alu;

  function automatic logic f3_legal(input logic [2:0] f);
    case (f)
      3'b000, 3'b010, 3'b100, 3'b110, 3'b111: f3_legal = 1'b1;
      default:                                f3_legal = 1'b0;
    endcase
  endfunction

  assign mem_busy  = (state_q == StFetch) || (state_q == StMemRead) || (state_q == StMemWrite);
  assign timed_out = mem_busy && !mem_ready && (cnt_q == TimeoutLast);

  always_comb begin
    exec_alu = 3'b000;
    case (funct3)
      3'b000:  exec_alu = ((state_q == StExecR) && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  exec_alu = 3'b010;
      3'b100:  exec_alu = 3'b100;
      3'b110:  exec_alu = 3'b110;
      3'b111:  exec_alu = 3'b111;
      default: exec_alu = 3'b000;
    endcase
  end

  // Next state and timeout counter; the counter only runs while a request is outstanding,
  // so every entry into a requesting state starts from zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    if (mem_busy && !mem_ready) begin
      cnt_d = cnt_q + 8'd1;
    end
    case (state_q)
      StFetch: begin
        if (mem_ready)      state_d = StDecode;
        else if (timed_out) state_d = StTrap;
      end
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpReg:           state_d = StExecR;
          OpImm:           state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:  state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
      StMemRead: begin
        if (mem_ready)      state_d = StMemWb;
        else if (timed_out) state_d = StTrap;
      end
      StMemWb:   state_d = StFetch;
      StMemWrite: begin
        if (mem_ready)      state_d = StFetch;
        else if (timed_out) state_d = StTrap;
      end
      StExecR, StExecI: state_d = f3_legal(funct3) ? StAluWb : StTrap;
      StAluWb:   state_d = StFetch;
      StBranch:  state_d = (funct3 == 3'b000) ? StFetch : StTrap;
      StJal:     state_d = StAluWb;
      StTrap:    state_d = StTrap;
      default:   state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 3'b000;
    trap        = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      StExecR: begin
        alu_src_a   = 2'b10;
        alu_control = exec_alu;
      end
      StExecI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = exec_alu;
      end
      StAluWb: reg_write = 1'b1;
      StBranch: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        // Non-beq encodings trap next cycle, so they must not redirect the PC.
        pc_write    = zero && (funct3 == 3'b000);
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      StTrap:  trap = 1'b1;
      default: trap = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction table checks, directed wait/timeout/reset sequences and
// random instruction streams compared cycle by cycle against an instruction-level step model.
module tb_mc_control;

  localparam int Tmo = 16;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpEcall  = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, trap;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;

  always #5 clk = ~clk;

  mc_control #(.MEM_TIMEOUT(Tmo)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .alu_control(alu_control),
    .trap       (trap)
  );

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res;
    logic [2:0] alu;
    logic       trap;
  } outs_t;

  outs_t got;
  assign got = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_control, trap};

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       rdy;
    outs_t      e;
    string      nm;
  } step_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         lat;
    logic       chk_alu;
    logic [2:0] alu3;
    int         regw;
    int         pcw;
    logic       trp;
    string      nm;
  } vec_t;

  step_t      plan[$];
  vec_t       tbl[15];
  int         total = 0;
  int         bad = 0;
  int         dreq_cnt, wb_cnt;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7, cur_z;
  int         waits[7] = '{0, 0, 1, 2, 3, Tmo - 1, Tmo};
  logic [2:0] legal_f3[5] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
  logic [6:0] bad_ops[4] = '{OpEcall, 7'b0110111, 7'b0000000, 7'b0010111};

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected control word for each step, straight from the per-state output table.
  function automatic outs_t o_mem(input int kind, input logic rdy);
    outs_t o;
    o = '0;
    o.mem_req = 1'b1;
    if (kind == 0) begin
      o.src_b    = 2'b10;
      o.ir_write = rdy;
      o.pc_write = rdy;
    end else begin
      o.adr_src = 1'b1;
      o.mem_we  = (kind == 2);
    end
    return o;
  endfunction

  function automatic outs_t o_step(input string kind, input logic [2:0] alu, input logic z);
    outs_t o;
    o = '0;
    case (kind)
      "decode": begin o.src_a = 2'b01; o.src_b = 2'b01; end
      "memadr": begin o.src_a = 2'b10; o.src_b = 2'b01; end
      "memwb":  begin o.res = 2'b01; o.reg_write = 1'b1; end
      "exec_r": begin o.src_a = 2'b10; o.alu = alu; end
      "exec_i": begin o.src_a = 2'b10; o.src_b = 2'b01; o.alu = alu; end
      "aluwb":  o.reg_write = 1'b1;
      "branch": begin o.src_a = 2'b10; o.alu = 3'b001; o.pc_write = z; end
      "jal":    begin o.src_a = 2'b01; o.src_b = 2'b10; o.pc_write = 1'b1; end
      default:  o.trap = 1'b1;
    endcase
    return o;
  endfunction

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
    if (f3 == 3'b000) return sub ? 3'b001 : 3'b000;
    return f3;
  endfunction

  task automatic push(input logic rdy, input outs_t e, input string nm);
    step_t s;
    s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7; s.z = cur_z;
    s.rdy = rdy; s.e = e; s.nm = nm;
    plan.push_back(s);
  endtask

  // A memory access: w idle cycles then ready, or a trap once Tmo idle cycles have passed.
  task automatic push_mem(input int kind, input int w, output bit trapped);
    int nwait;
    nwait   = (w >= Tmo) ? Tmo : w;
    trapped = (w >= Tmo);
    for (int i = 0; i < nwait; i++) push(1'b0, o_mem(kind, 1'b0), "mem_wait");
    if (trapped) push(rnd(), o_step("trap", 3'b000, 1'b0), "timeout_trap");
    else         push(1'b1, o_mem(kind, 1'b1), "mem_done");
  endtask

  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic z, input int fw, input int dw);
    bit tr;
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_z = z;
    plan.delete();
    push_mem(0, fw, tr);
    if (tr) return;
    push(rnd(), o_step("decode", 3'b000, 1'b0), "decode");
    case (op)
      OpLoad: begin
        push(rnd(), o_step("memadr", 3'b000, 1'b0), "memadr");
        push_mem(1, dw, tr);
        if (!tr) push(rnd(), o_step("memwb", 3'b000, 1'b0), "memwb");
      end
      OpStore: begin
        push(rnd(), o_step("memadr", 3'b000, 1'b0), "memadr");
        push_mem(2, dw, tr);
      end
      OpReg: begin
        push(rnd(), o_step("exec_r", alu_of(f3, f7), 1'b0), "exec_r");
        push(rnd(), o_step("aluwb", 3'b000, 1'b0), "aluwb");
      end
      OpImm: begin
        push(rnd(), o_step("exec_i", alu_of(f3, 1'b0), 1'b0), "exec_i");
        push(rnd(), o_step("aluwb", 3'b000, 1'b0), "aluwb");
      end
      OpBranch: push(rnd(), o_step("branch", 3'b000, z), "branch");
      OpJal: begin
        push(rnd(), o_step("jal", 3'b000, 1'b0), "jal");
        push(rnd(), o_step("aluwb", 3'b000, 1'b0), "aluwb");
      end
      default: push(rnd(), o_step("trap", 3'b000, 1'b0), "illegal_trap");
    endcase
  endtask

  task automatic run_plan(input string tag);
    foreach (plan[i]) begin
      @(negedge clk);
      opcode = plan[i].op; funct3 = plan[i].f3; funct7b5 = plan[i].f7;
      zero = plan[i].z; mem_ready = plan[i].rdy;
      #1;
      if (got.mem_req && got.adr_src) dreq_cnt++;
      if (got.reg_write && got.res == 2'b01) wb_cnt++;
      check({tag, ":", plan[i].nm}, int'(got), int'(plan[i].e));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    check("reset_outs", int'(got), int'(o_mem(0, 1'b0)));
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat, regw, pcw;
    logic [2:0] a3;
    logic trp;
    int cls, fw, dw;
    logic [6:0] op;
    logic [2:0] f3;
    logic f7, z;

    tbl[0]  = '{OpReg,    3'b000, 1'b0, 1'b0, 4, 1'b1, 3'b000, 1, 0, 1'b0, "add"};
    tbl[1]  = '{OpReg,    3'b000, 1'b1, 1'b0, 4, 1'b1, 3'b001, 1, 0, 1'b0, "sub"};
    tbl[2]  = '{OpReg,    3'b111, 1'b0, 1'b0, 4, 1'b1, 3'b111, 1, 0, 1'b0, "and"};
    tbl[3]  = '{OpReg,    3'b010, 1'b0, 1'b0, 4, 1'b1, 3'b010, 1, 0, 1'b0, "slt"};
    tbl[4]  = '{OpImm,    3'b000, 1'b1, 1'b0, 4, 1'b1, 3'b000, 1, 0, 1'b0, "addi"};
    tbl[5]  = '{OpImm,    3'b100, 1'b0, 1'b0, 4, 1'b1, 3'b100, 1, 0, 1'b0, "xori"};
    tbl[6]  = '{OpImm,    3'b110, 1'b0, 1'b0, 4, 1'b1, 3'b110, 1, 0, 1'b0, "ori"};
    tbl[7]  = '{OpLoad,   3'b010, 1'b0, 1'b0, 5, 1'b1, 3'b000, 1, 0, 1'b0, "lw"};
    tbl[8]  = '{OpStore,  3'b010, 1'b0, 1'b0, 4, 1'b1, 3'b000, 0, 0, 1'b0, "sw"};
    tbl[9]  = '{OpBranch, 3'b000, 1'b0, 1'b1, 3, 1'b1, 3'b001, 0, 1, 1'b0, "beq_taken"};
    tbl[10] = '{OpBranch, 3'b000, 1'b0, 1'b0, 3, 1'b1, 3'b001, 0, 0, 1'b0, "beq_not"};
    tbl[11] = '{OpJal,    3'b000, 1'b0, 1'b0, 4, 1'b1, 3'b000, 1, 1, 1'b0, "jal"};
    tbl[12] = '{OpEcall,  3'b000, 1'b0, 1'b0, 3, 1'b0, 3'b000, 0, 0, 1'b1, "ecall"};
    tbl[13] = '{OpReg,    3'b001, 1'b0, 1'b0, 4, 1'b0, 3'b000, 0, 0, 1'b1, "r_bad_f3"};
    tbl[14] = '{OpBranch, 3'b001, 1'b0, 1'b0, 4, 1'b1, 3'b001, 0, 0, 1'b1, "bne"};

    // Zero-wait memory: latency, ALU op in the third cycle, write-enable counts, trap.
    foreach (tbl[k]) begin
      do_reset();
      lat = 0; regw = 0; pcw = 0; a3 = 3'b000; trp = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        opcode = tbl[k].op; funct3 = tbl[k].f3; funct7b5 = tbl[k].f7;
        zero = tbl[k].z; mem_ready = 1'b1;
        #1;
        if (c == 3) a3 = got.alu;
        if (c > 1 && got.trap) begin
          trp = 1'b1;
          lat = c;
          break;
        end
        if (c > 1 && got.mem_req && !got.adr_src) begin
          lat = c - 1;
          break;
        end
        if (c > 1) begin
          regw += int'(got.reg_write);
          pcw  += int'(got.pc_write);
        end
      end
      check({tbl[k].nm, ":latency"}, lat, tbl[k].lat);
      check({tbl[k].nm, ":trap"}, int'(trp), int'(tbl[k].trp));
      check({tbl[k].nm, ":reg_write_cnt"}, regw, tbl[k].regw);
      check({tbl[k].nm, ":pc_write_cnt"}, pcw, tbl[k].pcw);
      if (tbl[k].chk_alu) check({tbl[k].nm, ":alu_control"}, int'(a3), int'(tbl[k].alu3));
    end

    // Load with the data response three cycles late.
    do_reset();
    build(OpLoad, 3'b010, 1'b0, 1'b0, 0, 3);
    dreq_cnt = 0; wb_cnt = 0;
    run_plan("lw_wait3");
    check("lw_wait3:data_req_cycles", dreq_cnt, 4);
    check("lw_wait3:mem_wb_once", wb_cnt, 1);

    // Fetch never answered: trap after Tmo cycles, then stays trapped.
    do_reset();
    build(OpReg, 3'b000, 1'b0, 1'b0, Tmo, 0);
    run_plan("fetch_timeout");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check("trap_sticky", int'(got), int'(o_step("trap", 3'b000, 1'b0)));
    end

    // Ready arriving on the last allowed cycle still completes the fetch.
    do_reset();
    build(OpReg, 3'b000, 1'b0, 1'b0, Tmo - 1, 0);
    run_plan("fetch_ready_last");

    do_reset();
    build(OpStore, 3'b010, 1'b0, 1'b0, 0, Tmo);
    run_plan("store_timeout");

    // Asynchronous reset in the middle of an unanswered store.
    do_reset();
    build(OpStore, 3'b010, 1'b0, 1'b0, 0, 20);
    while (plan.size() > 5) void'(plan.pop_back());
    run_plan("sw_pre_reset");
    @(posedge clk);
    #1;
    check("pre_reset_mem_we", int'(got.mem_we), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outs", int'(got), int'(o_mem(0, 1'b0)));
    @(posedge clk);
    #2 rst_n = 1'b1;
    build(OpReg, 3'b111, 1'b0, 1'b0, 1, 0);
    run_plan("after_async_reset");

    // Random instruction stream with random memory waits.
    for (int n = 0; n < 80; n++) begin
      cls = int'($urandom_range(0, 9));
      f3 = 3'b010; f7 = rnd(); z = rnd();
      case (cls)
        0, 1: op = OpLoad;
        2: op = OpStore;
        3, 4: begin op = OpReg; f3 = legal_f3[$urandom_range(0, 4)]; end
        5, 6: begin op = OpImm; f3 = legal_f3[$urandom_range(0, 4)]; end
        7: begin op = OpBranch; f3 = 3'b000; end
        8: op = OpJal;
        default: op = bad_ops[$urandom_range(0, 3)];
      endcase
      fw = waits[$urandom_range(0, 6)];
      dw = waits[$urandom_range(0, 6)];
      build(op, f3, f7, z, fw, dw);
      run_plan("rand");
      if (plan[plan.size() - 1].e.trap) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, 16, maximum cycles a memory request waits for mem_ready before trapping (range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  7  instruction[6:0], valid while ir holds current instruction.
REQ-005 funct3  input  3  instruction[14:12].
REQ-006 funct7b5  input  1  instruction[30].
REQ-007 zero  input  1  ALU zero flag, valid in the same cycle as alu_control.
REQ-008 mem_ready  input  1  memory completion strobe for the current mem_req.
REQ-009 mem_req  output  1  memory access request; held until mem_ready or timeout.
REQ-010 mem_we  output  1  write qualifier for mem_req.
REQ-011 adr_src  output  1  0 = PC, 1 = ALU result register as memory address.
REQ-012 ir_write, pc_write, reg_write  output  1 each  register enables.
REQ-013 alu_src_a  output  2  00 PC, 01 old PC, 10 rs1.
REQ-014 alu_src_b  output  2  00 rs2, 01 immediate, 10 constant 4.
REQ-015 result_src  output  2  00 ALU result register, 01 memory data, 10 live ALU output.
REQ-016 alu_control  output  3  000 add, 001 sub, 010 slt, 100 xor, 110 or, 111 and.
REQ-017 trap  output  1  sticky fault flag (illegal instruction or memory timeout).

Function
REQ-018 FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, TRAP.
REQ-019 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=000; on mem_ready assert ir_write and pc_write for that cycle only, then go to DECODE.
REQ-020 DECODE: alu_src_a=01, alu_src_b=01, add (branch target); next by opcode: 0000011/0100011 MEMADR, 0110011 EXEC_R, 0010011 EXEC_I, 1100011 BRANCH, 1101111 JAL, any other TRAP.
REQ-021 MEMADR: rs1 + imm; next MEMREAD for loads, MEMWRITE for stores.
REQ-022 MEMREAD: mem_req=1, adr_src=1, mem_we=0; on mem_ready go to MEMWB. MEMWB: result_src=01, reg_write=1, then FETCH.
REQ-023 MEMWRITE: mem_req=1, mem_we=1, adr_src=1; on mem_ready go to FETCH.
REQ-024 EXEC_R/EXEC_I: alu_src_a=10, alu_src_b=00 or 01; funct3 000 -> add, or sub when EXEC_R and funct7b5=1; 010 slt; 100 xor; 110 or; 111 and; other funct3 -> TRAP; else ALUWB.
REQ-025 ALUWB: result_src=00, reg_write=1, then FETCH.
REQ-026 BRANCH (beq only, funct3=000, else TRAP): rs1 - rs2 (sub); pc_write=zero, result_src=00; then FETCH.
REQ-027 JAL: alu_src_a=01, alu_src_b=10, add; result_src=00, pc_write=1; then ALUWB (writes old PC+4).
REQ-028 Timeout counter: 8 bits; cleared on entry to any state with mem_req=1 and on mem_ready; increments each cycle mem_req=1 and mem_ready=0; reaching MEM_TIMEOUT moves to TRAP next cycle with no enable asserted.
REQ-029 mem_ready while mem_req=0 is ignored; mem_ready in the same cycle as timeout reached: mem_ready wins.
REQ-030 TRAP: all enables and mem_req 0, trap=1; terminal until reset.
REQ-031 All outputs are combinational decodes of state; every enable not listed for a state is 0.
REQ-032 Per-instruction latency with zero-wait memory: load 5, store 4, R/I-type 4, beq 3, jal 4 cycles.

Reset
REQ-033 rst_n low: state FETCH, counter 0, trap 0, immediately and independent of clk; mid-transaction mem_req remains asserted (FETCH) and prior request is abandoned.
REQ-034 First FETCH after deassertion occurs on the first rising edge with rst_n high.

Verification
REQ-035 add x3,x1,x2 (0110011, f3=000, f7b5=0), ready immediate -> FETCH,DECODE,EXEC_R,ALUWB; alu_control 000; reg_write=1 in cycle 4.
REQ-036 sub (f7b5=1) then and (f3=111) -> alu_control 001 then 111 in EXEC_R.
REQ-037 lw with mem_ready delayed 3 cycles in MEMREAD -> mem_req held 4 cycles, reg_write with result_src=01 exactly once.
REQ-038 beq with zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; both return to FETCH.
REQ-039 opcode 1110011 -> TRAP after DECODE, trap=1; mem_ready withheld 16 cycles in FETCH -> TRAP.
REQ-040 rst_n pulsed low mid-MEMWRITE -> asynchronous return to FETCH, trap=0, mem_we=0 same cycle.
